// File: rtl/decode_stage.sv
// RV32I instruction decode stage: register file, immediate/control generation and ID/EX register.
// Optional feature macro DECODE_WRITE_BYPASS_EN: write-first register-file reads from the writeback port.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_fetch,
    input  logic [31:0] pc_fetch,
    input  logic [31:0] next_pc_fetch,
    input  logic        stall_decode,
    input  logic        flush_decode,
    input  logic        reg_write_writeback,
    input  logic [4:0]  rd_writeback,
    input  logic [31:0] result_writeback,
    output logic [31:0] rs1_data_execute,
    output logic [31:0] rs2_data_execute,
    output logic [31:0] imm_execute,
    output logic [31:0] pc_execute,
    output logic [31:0] next_pc_execute,
    output logic [4:0]  rs1_execute,
    output logic [4:0]  rs2_execute,
    output logic [4:0]  rd_execute,
    output logic [3:0]  alu_control_execute,
    output logic [1:0]  result_src_execute,
    output logic        reg_write_execute,
    output logic        mem_write_execute,
    output logic        alu_src_execute,
    output logic        branch_execute,
    output logic        jump_execute,
    output logic        jalr_execute,
    output logic        valid_execute,
    output logic        illegal_execute
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_MEM   = 2'b01;
    localparam logic [1:0] RES_NPC   = 2'b10;

    typedef struct packed {
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] nextPc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluControl;
        logic [1:0]  resultSrc;
        logic        regWrite;
        logic        memWrite;
        logic        aluSrc;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        valid;
        logic        illegal;
    } idex_t;

    function automatic idex_t bubbleValue();
        idex_t b;
        b        = '0;
        b.pc     = RESET_PC;
        b.nextPc = RESET_PC;
        return b;
    endfunction

    // alt selects sub (funct3=000) or sra (funct3=101); callers decide when it may apply.
    function automatic logic [3:0] aluFromFunct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immB;
    logic [31:0] immU;
    logic [31:0] immJ;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] regs_q [1:31];
    idex_t       idex_d;
    idex_t       idex_q;
    idex_t       decoded;

    assign opcode   = instruction_fetch[6:0];
    assign funct3   = instruction_fetch[14:12];
    assign funct7b5 = instruction_fetch[30];
    assign rs1Addr  = instruction_fetch[19:15];
    assign rs2Addr  = instruction_fetch[24:20];

    assign immI = {{20{instruction_fetch[31]}}, instruction_fetch[31:20]};
    assign immS = {{20{instruction_fetch[31]}}, instruction_fetch[31:25], instruction_fetch[11:7]};
    assign immB = {{19{instruction_fetch[31]}}, instruction_fetch[31], instruction_fetch[7],
                   instruction_fetch[30:25], instruction_fetch[11:8], 1'b0};
    assign immU = {instruction_fetch[31:12], 12'b0};
    assign immJ = {{11{instruction_fetch[31]}}, instruction_fetch[31], instruction_fetch[19:12],
                   instruction_fetch[20], instruction_fetch[30:21], 1'b0};

    // Register file: x0 is never stored, reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write_writeback && (rd_writeback != 5'd0)) begin
            regs_q[rd_writeback] <= result_writeback;
        end
    end

`ifdef DECODE_WRITE_BYPASS_EN
    logic wbActive;
    assign wbActive = reg_write_writeback && (rd_writeback != 5'd0);

    always_comb begin
        rs1Data = '0;
        rs2Data = '0;
        if (rs1Addr != 5'd0) rs1Data = regs_q[rs1Addr];
        if (rs2Addr != 5'd0) rs2Data = regs_q[rs2Addr];
        if (wbActive && (rd_writeback == rs1Addr)) rs1Data = result_writeback;
        if (wbActive && (rd_writeback == rs2Addr)) rs2Data = result_writeback;
    end
`else
    always_comb begin
        rs1Data = '0;
        rs2Data = '0;
        if (rs1Addr != 5'd0) rs1Data = regs_q[rs1Addr];
        if (rs2Addr != 5'd0) rs2Data = regs_q[rs2Addr];
    end
`endif

    // Register indices pass through unconditionally; the hazard unit qualifies them by opcode.
    always_comb begin
        decoded         = '0;
        decoded.valid   = 1'b1;
        decoded.pc      = pc_fetch;
        decoded.nextPc  = next_pc_fetch;
        decoded.rs1     = rs1Addr;
        decoded.rs2     = rs2Addr;
        decoded.rd      = instruction_fetch[11:7];
        decoded.rs1Data = rs1Data;
        decoded.rs2Data = rs2Data;
        case (opcode)
            OP_R: begin
                decoded.regWrite   = 1'b1;
                decoded.aluControl = aluFromFunct3(funct3, funct7b5);
            end
            OP_IMM: begin
                decoded.regWrite   = 1'b1;
                decoded.aluSrc     = 1'b1;
                decoded.imm        = immI;
                decoded.aluControl = aluFromFunct3(funct3, (funct3 == 3'b101) && funct7b5);
            end
            OP_LOAD: begin
                decoded.regWrite  = 1'b1;
                decoded.aluSrc    = 1'b1;
                decoded.imm       = immI;
                decoded.resultSrc = RES_MEM;
            end
            OP_STORE: begin
                decoded.memWrite = 1'b1;
                decoded.aluSrc   = 1'b1;
                decoded.imm      = immS;
            end
            OP_BRANCH: begin
                decoded.branch     = 1'b1;
                decoded.imm        = immB;
                decoded.aluControl = ALU_SUB;
            end
            OP_JAL: begin
                decoded.regWrite  = 1'b1;
                decoded.aluSrc    = 1'b1;
                decoded.jump      = 1'b1;
                decoded.imm       = immJ;
                decoded.resultSrc = RES_NPC;
            end
            OP_JALR: begin
                decoded.regWrite  = 1'b1;
                decoded.aluSrc    = 1'b1;
                decoded.jump      = 1'b1;
                decoded.jalr      = 1'b1;
                decoded.imm       = immI;
                decoded.resultSrc = RES_NPC;
            end
            OP_LUI: begin
                decoded.regWrite   = 1'b1;
                decoded.aluSrc     = 1'b1;
                decoded.imm        = immU;
                decoded.aluControl = ALU_PASSB;
            end
            OP_AUIPC: begin
                decoded.regWrite = 1'b1;
                decoded.aluSrc   = 1'b1;
                decoded.imm      = immU;
            end
            default: begin
                decoded.illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        idex_d = idex_q;
        if (flush_decode) begin
            idex_d = bubbleValue();
        end else if (!stall_decode) begin
            idex_d = decoded;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= bubbleValue();
        end else begin
            idex_q <= idex_d;
        end
    end

    assign rs1_data_execute    = idex_q.rs1Data;
    assign rs2_data_execute    = idex_q.rs2Data;
    assign imm_execute         = idex_q.imm;
    assign pc_execute          = idex_q.pc;
    assign next_pc_execute     = idex_q.nextPc;
    assign rs1_execute         = idex_q.rs1;
    assign rs2_execute         = idex_q.rs2;
    assign rd_execute          = idex_q.rd;
    assign alu_control_execute = idex_q.aluControl;
    assign result_src_execute  = idex_q.resultSrc;
    assign reg_write_execute   = idex_q.regWrite;
    assign mem_write_execute   = idex_q.memWrite;
    assign alu_src_execute     = idex_q.aluSrc;
    assign branch_execute      = idex_q.branch;
    assign jump_execute        = idex_q.jump;
    assign jalr_execute        = idex_q.jalr;
    assign valid_execute       = idex_q.valid;
    assign illegal_execute     = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, corner-case sequences and a randomized run.
// Honours DECODE_WRITE_BYPASS_EN the same way the design does.
module tb_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_fetch, pc_fetch, next_pc_fetch;
    logic        stall_decode, flush_decode;
    logic        reg_write_writeback;
    logic [4:0]  rd_writeback;
    logic [31:0] result_writeback;
    logic [31:0] rs1_data_execute, rs2_data_execute, imm_execute, pc_execute, next_pc_execute;
    logic [4:0]  rs1_execute, rs2_execute, rd_execute;
    logic [3:0]  alu_control_execute;
    logic [1:0]  result_src_execute;
    logic        reg_write_execute, mem_write_execute, alu_src_execute, branch_execute;
    logic        jump_execute, jalr_execute, valid_execute, illegal_execute;

    typedef struct packed {
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [1:0]  rsrc;
        logic [7:0]  ctrl;
    } outs_t;

    // ctrl bit order: regWrite, memWrite, aluSrc, branch, jump, jalr, valid, illegal
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  rsrc;
        logic [7:0]  ctrl;
    } vec_t;

    outs_t       dutOut;
    outs_t       expected;
    outs_t       held;
    logic [31:0] refRegs [32];
    logic [31:0] pcCnt;
    int          checks = 0;
    int          errors = 0;

    decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .instruction_fetch(instruction_fetch), .pc_fetch(pc_fetch), .next_pc_fetch(next_pc_fetch),
        .stall_decode(stall_decode), .flush_decode(flush_decode),
        .reg_write_writeback(reg_write_writeback), .rd_writeback(rd_writeback),
        .result_writeback(result_writeback),
        .rs1_data_execute(rs1_data_execute), .rs2_data_execute(rs2_data_execute),
        .imm_execute(imm_execute), .pc_execute(pc_execute), .next_pc_execute(next_pc_execute),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
        .alu_control_execute(alu_control_execute), .result_src_execute(result_src_execute),
        .reg_write_execute(reg_write_execute), .mem_write_execute(mem_write_execute),
        .alu_src_execute(alu_src_execute), .branch_execute(branch_execute),
        .jump_execute(jump_execute), .jalr_execute(jalr_execute),
        .valid_execute(valid_execute), .illegal_execute(illegal_execute)
    );

    always #5 clk = ~clk;

    assign dutOut = {rs1_data_execute, rs2_data_execute, imm_execute, pc_execute, next_pc_execute,
                     rs1_execute, rs2_execute, rd_execute, alu_control_execute, result_src_execute,
                     reg_write_execute, mem_write_execute, alu_src_execute, branch_execute,
                     jump_execute, jalr_execute, valid_execute, illegal_execute};

    function automatic outs_t bubble();
        outs_t o;
        o     = '0;
        o.pc  = RESET_PC;
        o.npc = RESET_PC;
        return o;
    endfunction

    // ALU code by mnemonic for each funct3; alt picks sub/sra.
    function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic alt);
        logic [3:0] plain [8];
        plain = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return plain[f3];
    endfunction

    function automatic outs_t refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] npc, input logic [31:0] d1,
                                        input logic [31:0] d2);
        outs_t o;
        int    iImm, sImm, bImm, jImm;
        logic  rw, mw, as, br, jp, jr, il;
        iImm = $signed(ins[31:20]);
        sImm = $signed({ins[31:25], ins[11:7]});
        bImm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        jImm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        o = '0;
        o.rs1Data = d1;  o.rs2Data = d2;
        o.pc = pc;       o.npc = npc;
        o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
        {rw, mw, as, br, jp, jr, il} = '0;
        case (ins[6:0])
            7'h33: begin rw = 1; o.alu = aluFor(ins[14:12], ins[30]); end
            7'h13: begin rw = 1; as = 1; o.imm = iImm;
                         o.alu = aluFor(ins[14:12], ins[14:12] == 3'd5 && ins[30]); end
            7'h03: begin rw = 1; as = 1; o.imm = iImm; o.rsrc = 2'd1; end
            7'h23: begin mw = 1; as = 1; o.imm = sImm; end
            7'h63: begin br = 1; o.imm = bImm; o.alu = 4'd1; end
            7'h6F: begin rw = 1; as = 1; jp = 1; o.imm = jImm; o.rsrc = 2'd2; end
            7'h67: begin rw = 1; as = 1; jp = 1; jr = 1; o.imm = iImm; o.rsrc = 2'd2; end
            7'h37: begin rw = 1; as = 1; o.imm = {ins[31:12], 12'h000}; o.alu = 4'd10; end
            7'h17: begin rw = 1; as = 1; o.imm = {ins[31:12], 12'h000}; end
            default: il = 1;
        endcase
        o.ctrl = {rw, mw, as, br, jp, jr, 1'b1, il};
        return o;
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] a, input logic we,
                                              input logic [4:0] wrd, input logic [31:0] wval);
        if (a == 5'd0) return 32'h0;
`ifdef DECODE_WRITE_BYPASS_EN
        if (we && wrd == a) return wval;
`endif
        return refRegs[a];
    endfunction

    // Drives one cycle of inputs, predicts the ID/EX contents and advances past the edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wval);
        instruction_fetch   = ins;
        pc_fetch            = pcCnt;
        next_pc_fetch       = pcCnt + 32'd4;
        stall_decode        = st;
        flush_decode        = fl;
        reg_write_writeback = we;
        rd_writeback        = wrd;
        result_writeback    = wval;
        if (fl) expected = bubble();
        else if (!st) expected = refDecode(ins, pcCnt, pcCnt + 32'd4,
                                           readModel(ins[19:15], we, wrd, wval),
                                           readModel(ins[24:20], we, wrd, wval));
        pcCnt = pcCnt + 32'd4;
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) refRegs[wrd] = wval;
        reg_write_writeback = 1'b0;
    endtask

    task automatic checkOutput(input string name, input outs_t want);
        checks++;
        if (dutOut !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, dutOut, want);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    vec_t vecs [12];
    logic [6:0] legalOps [9];

    initial begin
        vecs = '{
            '{32'hFFC10083, 32'hFFFFFFFC, 4'd0,  2'd1, 8'b1010_0010},
            '{32'hFE000EE3, 32'hFFFFFFFC, 4'd1,  2'd0, 8'b0001_0010},
            '{32'h123450B7, 32'h12345000, 4'd10, 2'd0, 8'b1010_0010},
            '{32'h0000007F, 32'h00000000, 4'd0,  2'd0, 8'b0000_0011},
            '{32'h003100B3, 32'h00000000, 4'd0,  2'd0, 8'b1000_0010},
            '{32'h40208033, 32'h00000000, 4'd1,  2'd0, 8'b1000_0010},
            '{32'h00112423, 32'h00000008, 4'd0,  2'd0, 8'b0110_0010},
            '{32'h010000EF, 32'h00000010, 4'd0,  2'd2, 8'b1010_1010},
            '{32'h004100E7, 32'h00000004, 4'd0,  2'd2, 8'b1010_1110},
            '{32'h00001097, 32'h00001000, 4'd0,  2'd0, 8'b1010_0010},
            '{32'h40315093, 32'h00000403, 4'd7,  2'd0, 8'b1010_0010},
            '{32'h003130B3, 32'h00000000, 4'd9,  2'd0, 8'b1000_0010}
        };
        legalOps = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
        pcCnt = 32'h100;

        rst = 1'b1;
        instruction_fetch = 32'h0; pc_fetch = 32'h0; next_pc_fetch = 32'h0;
        stall_decode = 1'b0; flush_decode = 1'b0;
        reg_write_writeback = 1'b0; rd_writeback = 5'd0; result_writeback = 32'h0;
        #12;
        checkOutput("reset_state", bubble());
        rst = 1'b0;
        @(posedge clk); #1;

        // Writeback then dependent add
        applyStimulus(32'h00000033, 0, 0, 1, 5'd3, 32'hDEADBEEF);
        applyStimulus(32'h003100B3, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("add_x1_x2_x3", expected);
        checkValue("add_rs2_data", rs2_data_execute, 32'hDEADBEEF);

        // Same-cycle write of x2 while sub reads it
        applyStimulus(32'h00000033, 0, 0, 1, 5'd2, 32'h00000011);
        applyStimulus(32'h40208033, 0, 0, 1, 5'd2, 32'h00000055);
        checkOutput("sub_same_cycle", expected);
`ifdef DECODE_WRITE_BYPASS_EN
        checkValue("sub_rs2_bypass", rs2_data_execute, 32'h00000055);
`else
        checkValue("sub_rs2_old", rs2_data_execute, 32'h00000011);
`endif
        applyStimulus(32'h00000033, 0, 0, 1, 5'd0, 32'h00000099);
        applyStimulus(32'h000000B3, 0, 0, 0, 5'd0, 32'h0);
        checkValue("x0_write_discarded", rs1_data_execute, 32'h0);

        // Directed decode table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].instr, 0, 0, 0, 5'd0, 32'h0);
            checkOutput($sformatf("table_model_%0d", i), expected);
            checks++;
            if ({imm_execute, alu_control_execute, result_src_execute, dutOut.ctrl} !==
                {vecs[i].imm, vecs[i].alu, vecs[i].rsrc, vecs[i].ctrl}) begin
                errors++;
                $display("[TB] FAIL table_%0d instr %h: got imm %h alu %h src %h ctrl %b required imm %h alu %h src %h ctrl %b",
                         i, vecs[i].instr, imm_execute, alu_control_execute, result_src_execute, dutOut.ctrl,
                         vecs[i].imm, vecs[i].alu, vecs[i].rsrc, vecs[i].ctrl);
            end
        end

        // Stall three cycles (with a writeback), then flush together with stall
        applyStimulus(32'h003100B3, 0, 0, 0, 5'd0, 32'h0);
        held = dutOut;
        checkOutput("pre_stall", expected);
        applyStimulus(32'h123450B7, 1, 0, 1, 5'd7, 32'h00001234);
        checkOutput("stall_1", held);
        applyStimulus(32'h0000007F, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("stall_2", held);
        applyStimulus(32'hFE000EE3, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("stall_3", held);
        applyStimulus(32'hFFC10083, 1, 1, 0, 5'd0, 32'h0);
        checkOutput("flush_with_stall", bubble());
        applyStimulus(32'h000380B3, 0, 0, 0, 5'd0, 32'h0);
        checkValue("stall_writeback_x7", rs1_data_execute, 32'h00001234);

        // Asynchronous reset mid-stall clears the pipe and the register file
        applyStimulus(32'h00000033, 0, 0, 1, 5'd5, 32'h0000ABCD);
        applyStimulus(32'h003100B3, 1, 0, 0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_now", bubble());
        @(posedge clk); #1;
        checkOutput("reset_held", bubble());
        #2 rst = 1'b0;
        for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
        expected = bubble();
        applyStimulus(32'h000280B3, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("x5_after_reset", expected);
        checkValue("x5_reads_zero", rs1_data_execute, 32'h0);

        // Randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, w;
            logic [6:0]  op;
            r = $urandom();
            w = $urandom();
            op = ($urandom_range(0, 9) == 0) ? r[6:0] : legalOps[$urandom_range(0, 8)];
            applyStimulus({r[31:7], op}, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                          w[0], w[5:1], $urandom());
            checkOutput($sformatf("random_%0d", n), expected);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I five-stage pipeline, directly downstream of the fetch stage. Consumes the fetched instruction and its PC pair, reads the 32x32 register file, generates the immediate and control bundle, and registers everything into the ID/EX boundary. Writeback writes the register file here. Stall and flush inputs come from the hazard unit.

## Interface
- RESET_PC, 32'h0: value loaded into pc_execute and next_pc_execute on reset.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instruction_fetch / pc_fetch / next_pc_fetch  in  32 each  from fetch stage
- stall_decode  in  1  hold all ID/EX outputs
- flush_decode  in  1  load a bubble into ID/EX
- reg_write_writeback  in  1; rd_writeback  in  5; result_writeback  in  32  register-file write port
- rs1_data_execute, rs2_data_execute, imm_execute, pc_execute, next_pc_execute  out  32 each
- rs1_execute, rs2_execute, rd_execute  out  5 each  register indices for forwarding
- alu_control_execute  out  4; result_src_execute  out  2
- reg_write_execute, mem_write_execute, alu_src_execute, branch_execute, jump_execute, jalr_execute, valid_execute, illegal_execute  out  1 each

## Operation
- Register file: 32x32, combinational read on instruction[19:15] and [24:20], synchronous write when reg_write_writeback=1 and rd_writeback!=0. x0 always reads 0.
- Immediates are sign-extended to 32 bits: I (load, OP-IMM, JALR), S (store), B (branch, bit0=0), U (LUI/AUIPC, low 12 bits 0), J (JAL, bit0=0). R-type gives imm=0.
- Decoded opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode sets illegal_execute=1, valid_execute=1, and clears reg_write, mem_write, branch, and jump.
- alu_control: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu, 1010 pass-B. Sub only on R-type funct7[5]=1. Shifts in OP-IMM also use funct7[5]. Branches use sub; LUI uses pass-B; AUIPC, JAL, JALR, loads, and stores use add.
- result_src: 00 ALU, 01 memory (loads), 10 next_pc (JAL/JALR).
- alu_src=1 for every non-R, non-branch opcode.
- Bubble: every output 0 except pc_execute and next_pc_execute = RESET_PC.
- Priority: rst > flush_decode > stall_decode > normal load. Register-file writes are unaffected by stall and flush.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the *_execute outputs after edge N.
- A write at edge N is visible to reads from edge N onward. Same-cycle read of the register being written is governed by Configuration.
- While rst is high: all outputs take bubble values, and all 31 registers clear to 0 asynchronously.
- If rst asserts mid-stall, the held values are lost and the bubble appears immediately.
- If flush and stall are high in the same cycle, a bubble is loaded.
- A stall held for K cycles keeps the outputs bit-identical for K cycles.

## Configuration
- DECODE_WRITE_BYPASS_EN defined: when reg_write_writeback=1, rd_writeback!=0, and it matches rs1 or rs2, the matching read returns result_writeback in the same cycle (write-first).
- Undefined: the read returns the old register value; the hazard unit must forward or stall.

## Test plan
- Reset: rst=1 mid-run -> all control outputs 0, pc_execute=RESET_PC. Once rst drops, reading x5 returns 0.
- Writeback x3=32'hDEADBEEF, then instruction 0x003100B3 (add x1,x2,x3) -> rs2_data_execute=DEADBEEF, alu_control=0000, reg_write=1, rd=1.
- Same-cycle write x2=0x55 with instruction 0x40208033 (sub x0,x1,x2) -> rs2_data=0x55 with the macro and the old value without. alu_control=0001; reg_write=1 with rd=0, and the later writeback of rd=0 is discarded.
- Immediates:
  - 0xFFC10083 (lb) -> imm=FFFFFFFC, result_src=01.
  - 0xFE000EE3 (beq, offset -4) -> imm=FFFFFFFC, branch=1.
  - 0x123450B7 (lui) -> imm=12345000, alu_control=1010.
- Illegal 0x0000007F -> illegal=1, reg_write=0, mem_write=0.
- Stall 3 cycles, then flush together with stall -> outputs frozen for 3 cycles, then a bubble. A writeback during the stall still updates the register file.
